// File: rtl/receptor_ctrl.sv
// Sequencing controller for the receptor shift register: one shift per bit_tick,
// a dump cycle per word, then a valid/ready hand-off, NWORDS words per frame.
module receptor_ctrl #(
    parameter int SIZESREG = 16,
    parameter int NWORDS   = 4,
    parameter int BCNT_W   = $clog2(SIZESREG),
    parameter int WCNT_W   = (NWORDS > 1 ? $clog2(NWORDS) : 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              abort,
    input  logic              bit_tick,
    input  logic              word_ready,
    output logic              sr_enable,
    output logic              word_valid,
    output logic              busy,
    output logic [BCNT_W-1:0] bit_cnt,
    output logic [WCNT_W-1:0] word_cnt,
    output logic              frame_done,
    output logic              overrun
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DUMP,
        VALID
    } state_e;

    localparam logic [BCNT_W-1:0] BIT_LAST  = BCNT_W'(SIZESREG - 1);
    localparam logic [WCNT_W-1:0] WORD_LAST = WCNT_W'(NWORDS - 1);

    state_e              state_q, state_d;
    logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic                word_valid_q, word_valid_d;
    logic                frame_done_q, frame_done_d;
    logic                overrun_q, overrun_d;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SHIFT;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    overrun_d  = 1'b0;
                end
            end
            SHIFT: begin
                if (bit_tick) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d   = DUMP;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCNT_W'(1);
                    end
                end
            end
            DUMP: begin
                state_d = VALID;
                if (bit_tick) overrun_d = 1'b1;
            end
            VALID: begin
                if (bit_tick) overrun_d = 1'b1;
                if (word_ready) begin
                    if (word_cnt_q == WORD_LAST) begin
                        state_d      = IDLE;
                        word_cnt_d   = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d    = SHIFT;
                        word_cnt_d = word_cnt_q + WCNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // abort overrides everything but leaves the sticky overrun alone
        if (abort) begin
            state_d      = IDLE;
            bit_cnt_d    = '0;
            word_cnt_d   = '0;
            frame_done_d = 1'b0;
            overrun_d    = overrun_q;
        end

        word_valid_d = (state_d == VALID);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            word_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            word_valid_q <= word_valid_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign sr_enable  = (state_q == SHIFT) & bit_tick & ~abort & ~RST;
    assign word_valid = word_valid_q;
    assign busy       = (state_q != IDLE);
    assign bit_cnt    = bit_cnt_q;
    assign word_cnt   = word_cnt_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_receptor_ctrl.sv
// Bench for receptor_ctrl with a behavioural receptor shift register and a
// scoreboard of expected words checked when word_valid rises.
module tb_receptor_ctrl;

    localparam int SZ = 16;
    localparam int NW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        bit_tick = 1'b0;
    logic        word_ready = 1'b0;
    logic        signal_in = 1'b0;
    logic        sr_enable;
    logic        word_valid;
    logic        busy;
    logic [3:0]  bit_cnt;
    logic [1:0]  word_cnt;
    logic        frame_done;
    logic        overrun;

    logic [15:0] shift_reg = '0;
    logic [15:0] output_reg = '0;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int en_cnt = 0;
    int fd_cnt = 0;
    int pop_cnt = 0;
    logic wv_prev = 1'b0;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;
    exp_t sbq[$];

    receptor_ctrl #(.SIZESREG(SZ), .NWORDS(NW)) dut (
        .CLK(clk), .RST(rst), .start(start), .abort(abort),
        .bit_tick(bit_tick), .word_ready(word_ready),
        .sr_enable(sr_enable), .word_valid(word_valid), .busy(busy),
        .bit_cnt(bit_cnt), .word_cnt(word_cnt),
        .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sr_enable) shift_reg <= {shift_reg[14:0], signal_in};
        else           output_reg <= shift_reg;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: pops one expected word at each rising word_valid
    always @(negedge clk) begin
        if (!busy) en_cnt = 0;
        else if (sr_enable) en_cnt++;
        if (frame_done) fd_cnt++;
        if (word_valid && !wv_prev) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_word", 32'(output_reg), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                pop_cnt++;
                chk("word_data", 32'(output_reg), 32'(e.data));
                chk("word_latency", 32'(cyc), 32'(e.cyc));
                chk("enable_count", 32'(en_cnt), 32'(SZ));
            end
            en_cnt = 0;
        end
        wv_prev = word_valid;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [15:0] w, input int n, input int gap);
        for (int i = 15; i >= 16 - n; i--) begin
            signal_in = w[i];
            bit_tick  = 1'b1;
            if (i == 0) sbq.push_back('{data: w, cyc: cyc + 2});
            step();
            bit_tick = 1'b0;
            repeat (gap - 1) step();
        end
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 40 && !word_valid; i++) step();
        chk("valid_timeout", 32'(word_valid), 32'd1);
    endtask

    task automatic accept();
        word_ready = 1'b1;
        step();
        word_ready = 1'b0;
    endtask

    logic [15:0] held;
    int          fd0;
    int          pop0;

    initial begin
        step();
        step();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_bit_cnt", 32'(bit_cnt), 0);
        chk("rst_word_cnt", 32'(word_cnt), 0);
        chk("rst_valid", 32'(word_valid), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_enable", 32'(sr_enable), 0);

        // ticks in IDLE are ignored
        repeat (3) begin
            bit_tick = 1'b1;
            step();
            bit_tick = 1'b0;
        end
        chk("idle_tick_overrun", 32'(overrun), 0);
        chk("idle_tick_busy", 32'(busy), 0);

        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle", 32'(busy), 0);

        // full frame with ready held high
        word_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy", 32'(busy), 1);
        chk("start_bit_cnt", 32'(bit_cnt), 0);
        send_bits(16'hA5C3, 16, 3);
        repeat (3) step();
        chk("frame_word_cnt1", 32'(word_cnt), 1);
        send_bits(16'h1234, 16, 1);
        repeat (3) step();
        send_bits(16'hBEEF, 16, 2);
        repeat (3) step();
        send_bits(16'h0F0F, 16, 1);
        repeat (3) step();
        chk("frame1_done_cnt", 32'(fd_cnt), 1);
        chk("frame1_busy", 32'(busy), 0);
        chk("frame1_word_cnt", 32'(word_cnt), 0);
        chk("frame1_valid_low", 32'(word_valid), 0);

        // back-pressure, overrun ticks and start while VALID
        word_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        send_bits(16'h1234, 16, 1);
        wait_valid();
        held = output_reg;
        for (int i = 0; i < 10; i++) begin
            bit_tick = (i == 2 || i == 5);
            start = (i == 7);
            step();
            bit_tick = 1'b0;
            start = 1'b0;
            chk("bp_valid_held", 32'(word_valid), 1);
            chk("bp_data_held", 32'(output_reg), 32'(held));
        end
        chk("ovr_set", 32'(overrun), 1);
        chk("ovr_bit_cnt", 32'(bit_cnt), 0);
        chk("bp_word_cnt", 32'(word_cnt), 0);
        accept();
        chk("bp_valid_drop", 32'(word_valid), 0);
        chk("bp_word_cnt1", 32'(word_cnt), 1);
        chk("bp_busy", 32'(busy), 1);
        fd0 = fd_cnt;
        send_bits(16'hBEEF, 16, 1);
        wait_valid();
        word_ready = 1'b1;
        step();
        send_bits(16'h5A5A, 16, 2);
        repeat (3) step();
        send_bits(16'hFFFF, 16, 1);
        repeat (3) step();
        word_ready = 1'b0;
        chk("bp_frame_done", 32'(fd_cnt - fd0), 1);
        chk("bp_word_cnt0", 32'(word_cnt), 0);
        chk("ovr_persist_idle", 32'(overrun), 1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ovr_cleared", 32'(overrun), 0);

        // abort after 7 bits, same cycle as a tick; start in SHIFT ignored
        send_bits(16'hF000, 7, 1);
        chk("abort_pre_bits", 32'(bit_cnt), 7);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("shift_start_bits", 32'(bit_cnt), 7);
        chk("shift_start_wcnt", 32'(word_cnt), 0);
        bit_tick = 1'b1;
        abort = 1'b1;
        #1;
        chk("abort_enable", 32'(sr_enable), 0);
        step();
        bit_tick = 1'b0;
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_bit_cnt", 32'(bit_cnt), 0);

        // abort during VALID
        fd0 = fd_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        send_bits(16'hC0DE, 16, 1);
        wait_valid();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abortv_valid", 32'(word_valid), 0);
        chk("abortv_busy", 32'(busy), 0);
        step();
        chk("abortv_no_done", 32'(fd_cnt - fd0), 0);

        // reset mid-word, then a full frame
        start = 1'b1;
        step();
        start = 1'b0;
        send_bits(16'h8001, 9, 1);
        chk("mid_bits", 32'(bit_cnt), 9);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_all", {busy, word_valid, frame_done, overrun, sr_enable,
                         2'(word_cnt), 4'(bit_cnt)}, 0);
        fd0 = fd_cnt;
        pop0 = pop_cnt;
        word_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        send_bits(16'h0001, 16, 1);
        repeat (3) step();
        send_bits(16'h8000, 16, 2);
        repeat (3) step();
        send_bits(16'h3C3C, 16, 1);
        repeat (3) step();
        send_bits(16'hDEAD, 16, 3);
        repeat (3) step();
        chk("mrst_words", 32'(pop_cnt - pop0), 4);
        chk("mrst_frame_done", 32'(fd_cnt - fd0), 1);
        chk("mrst_idle", 32'(busy), 0);
        chk("sb_empty", 32'(sbq.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/receptor_ctrl.md
Name:
receptor_ctrl

Overview:
- Sequencing controller for the `receptor` shift register.
- Gates the receptor's `enable` so that exactly one bit shifts in per `bit_tick`.
- After SIZESREG bits, drops `enable` for the dump cycle and presents the captured word with a valid/ready handshake.
- Repeats for NWORDS words per frame, then returns to idle; flags bits that arrive while it cannot accept them.

Parameters:
- SIZESREG, 16, bits per word; must equal the receptor's SIZESREG; ≥2.
- NWORDS, 4, words per frame; ≥1.
- BCNT_W, $clog2(SIZESREG), width of the bit counter.
- WCNT_W, (NWORDS>1 ? $clog2(NWORDS) : 1), width of the word counter.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous active-high reset.
- start  in  1  frame start strobe; honoured only in IDLE.
- abort  in  1  cancels the frame from any state.
- bit_tick  in  1  one-cycle strobe; `signal_in` is valid at this edge.
- word_ready  in  1  consumer accepts the word.
- sr_enable  out  1  drives the receptor `enable`.
- word_valid  out  1  receptor `output_reg` holds a complete word.
- busy  out  1  state ≠ IDLE.
- bit_cnt  out  BCNT_W  bits shifted into the current word.
- word_cnt  out  WCNT_W  index of the current word in the frame.
- frame_done  out  1  one-cycle pulse after the last word is accepted.
- overrun  out  1  sticky flag: a tick arrived while the block was not shifting.

Behaviour:
- Reset: the sampling edge with RST=1 forces state=IDLE.
  - bit_cnt, word_cnt, word_valid, frame_done and overrun all go to 0.
  - sr_enable=0 from that cycle on.
- Priority at each edge: RST > abort > state logic.
- States: IDLE, SHIFT, DUMP, VALID.
- sr_enable is combinational: (state==SHIFT) & bit_tick & ~abort. It is 0 in every other state, so the receptor refreshes `output_reg` from `shift_reg` each such cycle.
- IDLE:
  - start=1 → SHIFT; bit_cnt=0; word_cnt=0; overrun cleared.
  - bit_tick in IDLE is ignored and does not set overrun.
- SHIFT:
  - Each bit_tick increments bit_cnt.
  - A tick with bit_cnt==SIZESREG-1 → DUMP and bit_cnt wraps to 0.
  - No tick means hold.
- DUMP:
  - Exactly one cycle; sr_enable=0, so the receptor latches the full word on this edge.
  - → VALID; word_valid registered to 1 in the first VALID cycle.
  - Latency: the last bit's tick edge plus 2 edges gives word_valid=1 with stable `output_reg`.
- VALID:
  - word_valid=1 is held, and data is stable, until word_ready=1 at an edge.
  - On acceptance, word_valid goes to 0 next cycle.
  - If word_cnt==NWORDS-1: → IDLE, word_cnt=0, frame_done=1 for one cycle.
  - Otherwise: word_cnt+1, → SHIFT.
  - If word_ready is already high on VALID entry, acceptance happens at the first VALID edge; the minimum VALID dwell is 1 cycle.
- Ticks in DUMP or VALID are dropped (no shift, bit_cnt unchanged) and set overrun=1.
  - overrun clears only on RST or on start accepted in IDLE.
- abort=1 in any state:
  - Next state IDLE; bit_cnt=0; word_cnt=0.
  - word_valid=0 and frame_done=0 next cycle.
  - overrun is held.
  - A same-cycle bit_tick is not shifted.
- start while busy: ignored, no side effects.
- Same-edge start+abort in IDLE: abort wins and the block stays IDLE.
- Reset mid-word: partial count discarded. The receptor's `shift_reg` contents are don't-care, because a new word always shifts in SIZESREG fresh bits before DUMP.

Test Plan:
- Reset then single word (NWORDS=1):
  - Stimulus: start, then 16 ticks spaced 3 cycles apart carrying 0xA5C3 MSB-first, word_ready=1.
  - Required: sr_enable high on exactly 16 cycles; word_valid=1 exactly 2 edges after the 16th tick with `output_reg`=0xA5C3; word_valid high 1 cycle; frame_done pulse; busy=0.
- Back-pressure (NWORDS=2):
  - Stimulus: hold word_ready=0 for 10 cycles after word 0 (0x1234); apply no ticks.
  - Required: word_valid and data stable for 10 cycles; after ready, word_cnt=1 and state=SHIFT.
  - Stimulus: word 1 = 0xBEEF.
  - Required: frame_done once; word_cnt returns to 0.
- Overrun:
  - Stimulus: 2 ticks injected while VALID.
  - Required: overrun=1 and bit_cnt unchanged; next word still captures 16 fresh ticks correctly; overrun persists to IDLE; next start clears it.
- Abort:
  - Stimulus: abort after 7 bits, same cycle as a tick.
  - Required: sr_enable=0 that cycle; IDLE next cycle with bit_cnt=0.
  - Stimulus: abort during VALID.
  - Required: word_valid drops next cycle; no frame_done.
- Ignored inputs:
  - Stimulus: start pulses in SHIFT and VALID.
  - Required: no counter or state change.
  - Stimulus: ticks in IDLE.
  - Required: overrun stays 0.
  - Stimulus: start+abort together in IDLE.
  - Required: stays IDLE.
- Reset mid-operation:
  - Stimulus: RST asserted during SHIFT with bit_cnt=9, then released, then a full frame of 4 words.
  - Required: all outputs 0 the cycle after RST is sampled; the subsequent 4-word frame completes with 4 words and 1 frame_done.
